// File: rtl/usb_endp_pkg.sv
// ---------------------------------------------------------------------------
// usb_endp_pkg
//   Shared definitions for the USB IN endpoint register block.
//   - endp_state_t : transmit state machine encoding (also visible on the
//                    dbg_state port of usb_endpi_regs).
//   - CTRL_*       : bit positions inside the ENDPIn_CONTROL register.
// ---------------------------------------------------------------------------
package usb_endp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // CPU owns the buffer
    ARMED   = 2'd1,  // packet ready, waiting for an IN token
    SEND    = 2'd2,  // streaming bytes to the SIE transmitter
    WAIT_HS = 2'd3   // packet sent, waiting for ACK or timeout
  } endp_state_t;

  // CONTROL register layout
  localparam int CTRL_CNT_W = 7;   // [6:0] byte count (read-only)
  localparam int CTRL_READY = 8;   // write 1 arms the endpoint
  localparam int CTRL_TOGGLE = 9;  // DATA0/1 toggle (read-only)
  localparam int CTRL_STALL = 10;  // STALL enable (ENDP_STALL_EN builds only)
  localparam int CTRL_FLUSH = 11;  // write 1 empties the buffer, reads 0
  localparam int CTRL_DONE = 12;   // packet acknowledged, write 1 to clear
  localparam int CTRL_OVR = 13;    // rejected data write, write 1 to clear

endpackage

// File: rtl/endp_buf.sv
// ---------------------------------------------------------------------------
// endp_buf
//   DEPTH x 8 packet buffer, one write port and one read port.
//   The read is registered: rd_data presents mem[rd_addr] one cycle after
//   rd_addr is applied. The top drives rd_addr with the *next* read pointer,
//   so the byte at the current pointer is always waiting on rd_data.
// Ports
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write byte
//   rd_addr  in   read address (sampled every cycle)
//   rd_data  out  registered read byte
// ---------------------------------------------------------------------------
module endp_buf #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [7:0]               wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [7:0]               rd_data
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data_d;
  logic [7:0] rd_data_q;

  assign rd_data_d = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/usb_endpi_regs.sv
// ---------------------------------------------------------------------------
// usb_endpi_regs
//   Device-side register block for one USB IN endpoint. The CPU fills a byte
//   buffer through the DATA register (CTRL_ADDR+2) and arms the endpoint via
//   the CONTROL register (CTRL_ADDR). On an IN token the buffer is streamed to
//   the SIE transmitter; the block then waits for the host handshake and keeps
//   the DATA0/DATA1 toggle.
//
//   Build option: define ENDP_STALL_EN to make CONTROL[10] a read/write STALL
//   bit that answers IN tokens with tx_stall. Without it bit 10 reads 0 and
//   tx_stall is tied low.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   io_addr/we/re     CPU I/O address and one-cycle write / read strobes
//   io_wdata          CPU write data
//   io_rdata          read data, registered: valid the cycle after io_re
//   in_token          IN token for this endpoint decoded (pulse)
//   setup_rcvd        SETUP received on this endpoint number (pulse)
//   hs_ack            host ACK received (pulse)
//   hs_timeout        handshake timeout (pulse)
//   tx_data/valid     packet byte, valid held until tx_ready
//   tx_ready          SIE consumed the byte this cycle
//   tx_last           final byte of the packet (with tx_valid)
//   tx_zlp            send a zero-length DATA packet (pulse)
//   tx_pid_data1      1 = DATA1 PID, 0 = DATA0 PID
//   tx_nak            reply NAK (pulse)
//   tx_stall          reply STALL (pulse)
//   dbg_state         current endp_state_t encoding
//
// Handshake: a byte moves from this block to the SIE on every rising edge
// where tx_valid and tx_ready are both high; tx_data/tx_last stay stable
// while tx_valid is high and tx_ready is low.
//
// Event ordering within one cycle: setup_rcvd beats every other SIE event;
// SIE events are evaluated first and a CPU write then applies to the state
// they produced.
// ---------------------------------------------------------------------------
module usb_endpi_regs
  import usb_endp_pkg::*;
#(
  parameter logic [15:0] CTRL_ADDR = 16'h5000,
  parameter int          DEPTH     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] io_addr,
  input  logic        io_we,
  input  logic        io_re,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_rdata,
  input  logic        in_token,
  input  logic        setup_rcvd,
  input  logic        hs_ack,
  input  logic        hs_timeout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        tx_zlp,
  output logic        tx_pid_data1,
  output logic        tx_nak,
  output logic        tx_stall,
  output logic [1:0]  dbg_state
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [15:0] DATA_ADDR = CTRL_ADDR + 16'd2;
  localparam logic [AW:0] FULL      = (AW+1)'(DEPTH);

  endp_state_t state_q, state_d;
  logic [AW:0]   wptr_q, wptr_d;   // doubles as the byte count
  logic [AW-1:0] rptr_q, rptr_d;
  logic          toggle_q, toggle_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic          nak_q, nak_d;
  logic          zlp_q, zlp_d;
  logic [15:0]   rdata_q, rdata_d;

  logic          hit_ctrl, hit_data, ctrl_wr, data_wr;
  logic          is_last;
  logic          stall_q;
  logic          stall_hit;        // IN token answered with STALL this cycle
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [7:0]    buf_rdata;
  logic [15:0]   ctrl_word;
  logic          unused_wdata;

  assign hit_ctrl = (io_addr == CTRL_ADDR);
  assign hit_data = (io_addr == DATA_ADDR);
  assign ctrl_wr  = io_we && hit_ctrl;
  assign data_wr  = io_we && hit_data;
  assign is_last  = ({1'b0, rptr_q} == (wptr_q - (AW+1)'(1)));

  // Bits that carry no write meaning in this register map.
  assign unused_wdata = ^{io_wdata[15:14], io_wdata[10:9]};

`ifdef ENDP_STALL_EN
  logic stall_d;
  logic tx_stall_q;

  // STALL answers tokens in every state except SEND, where the token is
  // ignored like any other mid-packet token.
  assign stall_hit = in_token && stall_q && (state_q != SEND) && !setup_rcvd;

  always_comb begin
    stall_d = stall_q;
    if (setup_rcvd) stall_d = 1'b0;
    if (ctrl_wr)    stall_d = io_wdata[CTRL_STALL];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q    <= 1'b0;
      tx_stall_q <= 1'b0;
    end else begin
      stall_q    <= stall_d;
      tx_stall_q <= stall_hit;
    end
  end

  assign tx_stall = tx_stall_q;
`else
  assign stall_q   = 1'b0;
  assign stall_hit = 1'b0;
  assign tx_stall  = 1'b0;
`endif

  always_comb begin
    ctrl_word                   = '0;
    ctrl_word[CTRL_CNT_W-1:0]   = CTRL_CNT_W'(wptr_q);
    ctrl_word[CTRL_READY]       = (state_q != IDLE);
    ctrl_word[CTRL_TOGGLE]      = toggle_q;
    ctrl_word[CTRL_STALL]       = stall_q;
    ctrl_word[CTRL_DONE]        = done_q;
    ctrl_word[CTRL_OVR]         = ovr_q;
  end

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    toggle_d  = toggle_q;
    done_d    = done_q;
    ovr_d     = ovr_q;
    nak_d     = 1'b0;
    zlp_d     = 1'b0;
    rdata_d   = '0;
    buf_we    = 1'b0;
    buf_waddr = '0;

    // ---- SIE events ----
    if (setup_rcvd) begin
      state_d  = IDLE;
      wptr_d   = '0;
      rptr_d   = '0;
      toggle_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_token && !stall_hit) nak_d = 1'b1;
        end
        ARMED: begin
          if (in_token && !stall_hit) begin
            rptr_d = '0;
            if (wptr_q == '0) begin
              zlp_d   = 1'b1;
              state_d = WAIT_HS;
            end else begin
              state_d = SEND;
            end
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (is_last) state_d = WAIT_HS;
            else         rptr_d  = rptr_q + AW'(1);
          end
        end
        WAIT_HS: begin
          if (hs_ack) begin
            toggle_d = ~toggle_q;
            done_d   = 1'b1;
            wptr_d   = '0;
            rptr_d   = '0;
            state_d  = IDLE;
          end else if (hs_timeout) begin
            // Retransmit the same packet with the same PID on the next token.
            rptr_d  = '0;
            state_d = ARMED;
          end
        end
      endcase
    end

    // ---- CPU writes, applied on top of the SIE result ----
    if (ctrl_wr) begin
      if (io_wdata[CTRL_DONE]) done_d = 1'b0;
      if (io_wdata[CTRL_OVR])  ovr_d  = 1'b0;
      // FLUSH wins over a READY written in the same word.
      if (io_wdata[CTRL_FLUSH]) begin
        state_d = IDLE;
        wptr_d  = '0;
        rptr_d  = '0;
      end else if (io_wdata[CTRL_READY] && (state_d == IDLE)) begin
        state_d = ARMED;
      end
    end

    if (data_wr) begin
      if ((wptr_d == FULL) || (state_d != IDLE)) begin
        ovr_d = 1'b1;
      end else begin
        buf_we    = 1'b1;
        buf_waddr = wptr_d[AW-1:0];
        wptr_d    = wptr_d + (AW+1)'(1);
      end
    end

    // DATA reads return 0; only CONTROL has readable content.
    if (io_re && hit_ctrl) rdata_d = ctrl_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      toggle_q <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      nak_q    <= 1'b0;
      zlp_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      toggle_q <= toggle_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      nak_q    <= nak_d;
      zlp_q    <= zlp_d;
      rdata_q  <= rdata_d;
    end
  end

  // Reading at rptr_d keeps mem[rptr_q] on buf_rdata every cycle, so the next
  // byte is already present when tx_ready advances the pointer.
  endp_buf #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk    (clk),
    .wr_en  (buf_we),
    .wr_addr(buf_waddr),
    .wr_data(io_wdata[7:0]),
    .rd_addr(rptr_d),
    .rd_data(buf_rdata)
  );

  assign tx_valid     = (state_q == SEND);
  assign tx_data      = tx_valid ? buf_rdata : 8'h00;
  assign tx_last      = tx_valid && is_last;
  assign tx_zlp       = zlp_q;
  assign tx_nak       = nak_q;
  assign tx_pid_data1 = toggle_q;
  assign io_rdata     = rdata_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_usb_endpi_regs.sv
// ---------------------------------------------------------------------------
// tb_usb_endpi_regs
//   Directed bench for usb_endpi_regs. A table of per-cycle vectors covers
//   the basic send, zero-length, retransmit and NAK paths; hand-written
//   sequences cover buffer overflow, a full 64-byte packet, SETUP during a
//   transfer and the STALL option (ENDP_STALL_EN).
// ---------------------------------------------------------------------------
module tb_usb_endpi_regs;

  localparam logic [15:0] C = 16'h5000;
  localparam logic [15:0] D = 16'h5002;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] io_addr;
  logic        io_we, io_re;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;
  logic        in_token, setup_rcvd, hs_ack, hs_timeout;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_last, tx_zlp, tx_pid_data1, tx_nak, tx_stall;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  usb_endpi_regs dut (
    .clk         (clk),
    .reset       (reset),
    .io_addr     (io_addr),
    .io_we       (io_we),
    .io_re       (io_re),
    .io_wdata    (io_wdata),
    .io_rdata    (io_rdata),
    .in_token    (in_token),
    .setup_rcvd  (setup_rcvd),
    .hs_ack      (hs_ack),
    .hs_timeout  (hs_timeout),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_last     (tx_last),
    .tx_zlp      (tx_zlp),
    .tx_pid_data1(tx_pid_data1),
    .tx_nak      (tx_nak),
    .tx_stall    (tx_stall),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  // flags = {tx_valid, tx_last, tx_zlp, tx_pid_data1, tx_nak}, sampled after the edge
  typedef struct {
    string       name;
    logic [15:0] addr;
    logic        we, re;
    logic [15:0] wdata;
    logic        tok, su, ak, to, rdy;
    logic [15:0] e_rdata;
    logic [7:0]  e_data;
    logic [4:0]  e_flags;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic [15:0] a, input logic we, input logic re,
                     input logic [15:0] wd, input logic tok, input logic su, input logic ak,
                     input logic to, input logic rdy, input logic [15:0] e_rd,
                     input logic [7:0] e_d, input logic [4:0] e_fl, input logic [1:0] e_st);
    vec_t v;
    v.name = n; v.addr = a; v.we = we; v.re = re; v.wdata = wd;
    v.tok = tok; v.su = su; v.ak = ak; v.to = to; v.rdy = rdy;
    v.e_rdata = e_rd; v.e_data = e_d; v.e_flags = e_fl; v.e_state = e_st;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    io_addr = 16'h0; io_we = 1'b0; io_re = 1'b0; io_wdata = 16'h0;
    in_token = 1'b0; setup_rcvd = 1'b0; hs_ack = 1'b0; hs_timeout = 1'b0; tx_ready = 1'b0;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
    io_addr = a; io_wdata = d; io_we = 1'b1;
    cycle();
    io_we = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] a, output logic [15:0] d);
    io_addr = a; io_re = 1'b1;
    cycle();
    io_re = 1'b0;
    d = io_rdata;
  endtask

  task automatic apply(input vec_t v);
    io_addr = v.addr; io_we = v.we; io_re = v.re; io_wdata = v.wdata;
    in_token = v.tok; setup_rcvd = v.su; hs_ack = v.ak; hs_timeout = v.to; tx_ready = v.rdy;
    cycle();
    chk({v.name, ".rdata"}, 32'(io_rdata), 32'(v.e_rdata));
    chk({v.name, ".data"},  32'(tx_data),  32'(v.e_data));
    chk({v.name, ".flags"}, 32'({tx_valid, tx_last, tx_zlp, tx_pid_data1, tx_nak}), 32'(v.e_flags));
    chk({v.name, ".state"}, 32'({tx_stall, dbg_state}), 32'({1'b0, v.e_state}));
  endtask

  // ---------------- test ----------------
  initial begin
    logic [15:0] rd;
    int n;

    //   name        addr we re wdata    tok su ak to rdy  rdata    data   flags     state
    add("wr11",      D, 1, 0, 16'h0011, 0, 0, 0, 0, 0,   16'h0000, 8'h00, 5'b00000, 2'd0);
    add("wr22",      D, 1, 0, 16'h0022, 0, 0, 0, 0, 0,   16'h0000, 8'h00, 5'b00000, 2'd0);
    add("wr33",      D, 1, 0, 16'h0033, 0, 0, 0, 0, 0,   16'h0000, 8'h00, 5'b00000, 2'd0);
    add("rd_cnt",    C, 0, 1, 16'h0000, 0, 0, 0, 0, 0,   16'h0003, 8'h00, 5'b00000, 2'd0);
    add("arm",       C, 1, 0, 16'h0100, 0, 0, 0, 0, 0,   16'h0000, 8'h00, 5'b00000, 2'd1);
    add("rd_armed",  C, 0, 1, 16'h0000, 0, 0, 0, 0, 0,   16'h0103, 8'h00, 5'b00000, 2'd1);
    add("tok",       C, 0, 0, 16'h0000, 1, 0, 0, 0, 0,   16'h0000, 8'h11, 5'b10000, 2'd2);
    add("b0",        C, 0, 0, 16'h0000, 0, 0, 0, 0, 1,   16'h0000, 8'h22, 5'b10000, 2'd2);
    add("hold",      C, 0, 0, 16'h0000, 0, 0, 0, 0, 0,   16'h0000, 8'h22, 5'b10000, 2'd2);
    add("b1",        C, 0, 0, 16'h0000, 0, 0, 0, 0, 1,   16'h0000, 8'h33, 5'b11000, 2'd2);
    add("b2",        C, 0, 0, 16'h0000, 0, 0, 0, 0, 1,   16'h0000, 8'h00, 5'b00000, 2'd3);
    add("tok_wait",  C, 0, 0, 16'h0000, 1, 0, 0, 0, 0,   16'h0000, 8'h00, 5'b00000, 2'd3);
    add("ack",       C, 0, 0, 16'h0000, 0, 0, 1, 0, 0,   16'h0000, 8'h00, 5'b00010, 2'd0);
    add("rd_done",   C, 0, 1, 16'h0000, 0, 0, 0, 0, 0,   16'h1200, 8'h00, 5'b00010, 2'd0);
    add("arm0",      C, 1, 0, 16'h0100, 0, 0, 0, 0, 0,   16'h0000, 8'h00, 5'b00010, 2'd1);
    add("wr_busy",   D, 1, 0, 16'h0099, 0, 0, 0, 0, 0,   16'h0000, 8'h00, 5'b00010, 2'd1);
    add("zlp_tok",   C, 0, 0, 16'h0000, 1, 0, 0, 0, 0,   16'h0000, 8'h00, 5'b00110, 2'd3);
    add("zlp_gap",   C, 0, 0, 16'h0000, 0, 0, 0, 0, 0,   16'h0000, 8'h00, 5'b00010, 2'd3);
    add("zlp_ack",   C, 0, 0, 16'h0000, 0, 0, 1, 0, 0,   16'h0000, 8'h00, 5'b00000, 2'd0);
    add("rd_z",      C, 0, 1, 16'h0000, 0, 0, 0, 0, 0,   16'h3000, 8'h00, 5'b00000, 2'd0);
    add("clr",       C, 1, 0, 16'h3000, 0, 0, 0, 0, 0,   16'h0000, 8'h00, 5'b00000, 2'd0);
    add("rd_clr",    C, 0, 1, 16'h0000, 0, 0, 0, 0, 0,   16'h0000, 8'h00, 5'b00000, 2'd0);
    add("wrA",       D, 1, 0, 16'hFFA5, 0, 0, 0, 0, 0,   16'h0000, 8'h00, 5'b00000, 2'd0);
    add("wrB",       D, 1, 0, 16'h005A, 0, 0, 0, 0, 0,   16'h0000, 8'h00, 5'b00000, 2'd0);
    add("arm2",      C, 1, 0, 16'h0100, 0, 0, 0, 0, 0,   16'h0000, 8'h00, 5'b00000, 2'd1);
    add("tok2",      C, 0, 0, 16'h0000, 1, 0, 0, 0, 0,   16'h0000, 8'hA5, 5'b10000, 2'd2);
    add("r2b0",      C, 0, 0, 16'h0000, 0, 0, 0, 0, 1,   16'h0000, 8'h5A, 5'b11000, 2'd2);
    add("r2b1",      C, 0, 0, 16'h0000, 0, 0, 0, 0, 1,   16'h0000, 8'h00, 5'b00000, 2'd3);
    add("tmo",       C, 0, 0, 16'h0000, 0, 0, 0, 1, 0,   16'h0000, 8'h00, 5'b00000, 2'd1);
    add("retok",     C, 0, 0, 16'h0000, 1, 0, 0, 0, 0,   16'h0000, 8'hA5, 5'b10000, 2'd2);
    add("re_b0",     C, 0, 0, 16'h0000, 0, 0, 0, 0, 1,   16'h0000, 8'h5A, 5'b11000, 2'd2);
    add("re_b1",     C, 0, 0, 16'h0000, 0, 0, 0, 0, 1,   16'h0000, 8'h00, 5'b00000, 2'd3);
    add("ack_wr",    D, 1, 0, 16'h0077, 0, 0, 1, 0, 0,   16'h0000, 8'h00, 5'b00010, 2'd0);
    add("rd_mix",    C, 0, 1, 16'h0000, 0, 0, 0, 0, 0,   16'h1201, 8'h00, 5'b00010, 2'd0);
    add("nak_tok",   C, 0, 0, 16'h0000, 1, 0, 0, 0, 0,   16'h0000, 8'h00, 5'b00011, 2'd0);
    add("nak_gap",   C, 0, 0, 16'h0000, 0, 0, 0, 0, 0,   16'h0000, 8'h00, 5'b00010, 2'd0);
    add("rd_data",   D, 0, 1, 16'h0000, 0, 0, 0, 0, 0,   16'h0000, 8'h00, 5'b00010, 2'd0);

    idle_inputs();
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;

    chk("reset.rdata", 32'(io_rdata), 32'h0);
    chk("reset.outs", 32'({tx_data, tx_valid, tx_last, tx_zlp, tx_pid_data1, tx_nak, tx_stall}), 32'h0);
    chk("reset.state", 32'(dbg_state), 32'd0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
    idle_inputs();

    // ---- FLUSH, then overflow on the 65th byte ----
    cpu_wr(C, 16'h0800);
    cpu_rd(C, rd);
    chk("flush.ctrl", 32'(rd), 32'h1200);
    for (int i = 0; i < 65; i++) begin
      logic [7:0] b;
      b = 8'(i * 5 + 3);
      cpu_wr(D, {8'hEE, b});
      if (i < 64) exp_q.push_back(b);
    end
    cpu_rd(C, rd);
    chk("ovr.ctrl", 32'(rd), 32'h3240);

    // ---- full 64-byte packet, continuous tx_ready ----
    cpu_wr(C, 16'h0100);
    in_token = 1'b1;
    cycle();
    in_token = 1'b0;
    tx_ready = 1'b1;
    n = 0;
    while (tx_valid && n < 100) begin
      if (exp_q.size() == 0) begin
        chk("stream.extra_byte", 32'(tx_data), 32'hFFFF_FFFF);
        break;
      end
      begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk($sformatf("stream.data%0d", n), 32'(tx_data), 32'(e));
        chk($sformatf("stream.last%0d", n), 32'(tx_last), 32'(exp_q.size() == 0));
      end
      cycle();
      n++;
    end
    tx_ready = 1'b0;
    chk("stream.count", 32'(n), 32'd64);
    chk("stream.state", 32'(dbg_state), 32'd3);
    hs_ack = 1'b1;
    cycle();
    hs_ack = 1'b0;
    chk("full_ack.pid", 32'(tx_pid_data1), 32'd0);
    cpu_rd(C, rd);
    chk("full_ack.ctrl", 32'(rd), 32'h3000);

    // ---- SETUP in the middle of a transfer ----
    cpu_wr(D, 16'h00C1);
    cpu_wr(D, 16'h00C2);
    cpu_wr(C, 16'h0100);
    in_token = 1'b1;
    cycle();
    in_token = 1'b0;
    chk("setup.pre", 32'({tx_valid, tx_data}), 32'h1C1);
    setup_rcvd = 1'b1;
    cycle();
    setup_rcvd = 1'b0;
    chk("setup.valid", 32'(tx_valid), 32'd0);
    chk("setup.state", 32'(dbg_state), 32'd0);
    chk("setup.pid", 32'(tx_pid_data1), 32'd1);
    cpu_rd(C, rd);
    chk("setup.ctrl", 32'(rd), 32'h3200);

    // ---- STALL bit ----
    cpu_wr(C, 16'h0400);
    cpu_rd(C, rd);
`ifdef ENDP_STALL_EN
    chk("stall.ctrl", 32'(rd), 32'h3600);
`else
    chk("stall.ctrl", 32'(rd), 32'h3200);
`endif
    in_token = 1'b1;
    cycle();
    in_token = 1'b0;
`ifdef ENDP_STALL_EN
    chk("stall.reply", 32'({tx_stall, tx_nak, tx_valid}), 32'b100);
    setup_rcvd = 1'b1;
    cycle();
    setup_rcvd = 1'b0;
    cpu_rd(C, rd);
    chk("stall.setup_clr", 32'(rd), 32'h3200);
`else
    chk("stall.reply", 32'({tx_stall, tx_nak, tx_valid}), 32'b010);
`endif
    cycle();
    chk("end.pulses", 32'({tx_stall, tx_nak, tx_zlp}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
